vram_scanout: RTL

Parametrised pixel-fetch stage between the VGA timing generator and the frame-buffer VRAM. For every (row, col) it computes the VRAM read address, fetches the pixel and returns it with a fixed, documented latency. It supports configurable window geometry, integer pixel replication (scaling), tear-free horizontal scrolling with wrap-around, and a separate border colour. It replaces the fixed 512×480 fetch stage and corrects its output misalignment.

---
 rtl/gpu_pkg.sv | 15 +
 rtl/vram_scanout_if.sv | 12 +
 rtl/vram_scanout_delay_line.sv | 27 ++
 rtl/vram_scanout.sv | 106 ++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared video definitions: default pixel width, the black pixel and the
// per-pixel classification carried down the scan-out pipelines.
package gpu_pkg;

  localparam int DEF_PIX_W = 12;

  localparam logic [DEF_PIX_W-1:0] BLACK = '0;

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    BORDER = 2'd1,
    WINDOW = 2'd2
  } pix_class_e;

endpackage

// File: rtl/vram_scanout_if.sv
// Frame-buffer read port: the scan-out stage drives the address and VRAM
// returns the pixel a fixed number of cycles later.
interface vram_scanout_if #(
  parameter int ADDR_W = 18,
  parameter int PIX_W  = 12
);
  logic [ADDR_W-1:0] vram_addr;
  logic [PIX_W-1:0]  vram_data;

  modport master (output vram_addr, input vram_data);
  modport slave  (input vram_addr, output vram_data);
endinterface

// File: rtl/vram_scanout_delay_line.sv
// Generic fixed-depth delay line with a programmable reset value; shared by
// the video blocks to carry side-band flags alongside memory accesses.
module delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= RST_VAL;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/vram_scanout.sv
// Pixel-fetch stage between the VGA timing generator and the frame buffer:
// classifies each scan position, fetches windowed pixels with scrolling and
// scaling, and returns every pixel with a constant RD_LAT+2 latency.
module vram_scanout import gpu_pkg::*; #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int WIN_X0   = 64,
  parameter int WIN_W    = 256,
  parameter int WIN_H    = 240,
  parameter int SCALE    = 1,
  parameter int ADDR_W   = 18,
  parameter int PIX_W    = DEF_PIX_W,
  parameter int RD_LAT   = 1,
  parameter int ROW_W    = 9,
  parameter int COL_W    = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ROW_W-1:0]           row,
  input  logic [COL_W-1:0]           col,
  input  logic [$clog2(WIN_W)-1:0]   scroll_in,
  input  logic                       scroll_we,
  input  logic [PIX_W-1:0]           border_color,
  vram_scanout_if.master             vram,
  output logic [PIX_W-1:0]           vga_data,
  output logic                       frame_start
);

  localparam int SX_W  = $clog2(WIN_W);
  localparam int CAT_W = ROW_W + SX_W;

  logic [SX_W-1:0]   scroll_pend;
  logic [SX_W-1:0]   scroll_act;
  logic              frame_bnd_p0;
  logic [COL_W-1:0]  col_off_p0;
  logic [SX_W-1:0]   sx_p0;
  logic [ROW_W-1:0]  sy_p0;
  logic [CAT_W-1:0]  cat_p0;
  logic [ADDR_W-1:0] addr_p0;
  pix_class_e        cls_p0;
  logic [1:0]        cls_out;

  // Stage 0: classify the scan position and form the source address
  always_comb begin
    frame_bnd_p0 = (row == '0) && (col == '0);
    // Unsigned wrap makes columns left of the window land far above WIN_W<<SCALE.
    col_off_p0   = col - COL_W'(WIN_X0);
    sx_p0        = SX_W'(col_off_p0 >> SCALE) + scroll_act;
    sy_p0        = row >> SCALE;
    cat_p0       = {sy_p0, sx_p0};
    addr_p0      = ADDR_W'(cat_p0);
    if (32'(col) >= H_ACTIVE || 32'(row) >= V_ACTIVE)
      cls_p0 = BLANK;
    else if (32'(col_off_p0) < (WIN_W << SCALE) && 32'(row) < (WIN_H << SCALE))
      cls_p0 = WINDOW;
    else
      cls_p0 = BORDER;
  end

  // A write coincident with the (0,0) sample takes effect for that frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scroll_pend <= '0;
      scroll_act  <= '0;
    end else begin
      if (scroll_we) scroll_pend <= scroll_in;
      if (frame_bnd_p0) scroll_act <= scroll_we ? scroll_in : scroll_pend;
    end
  end

  // Stage 1: VRAM address issue; address holds outside the window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vram.vram_addr <= '0;
      frame_start    <= 1'b0;
    end else begin
      frame_start <= frame_bnd_p0;
      if (cls_p0 == WINDOW) vram.vram_addr <= addr_p0;
    end
  end

  delay_line #(
    .WIDTH   (2),
    .DEPTH   (RD_LAT + 1),
    .RST_VAL (BLANK)
  ) u_cls_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (cls_p0),
    .dout (cls_out)
  );

  // Stage RD_LAT+2: pixel select, aligned with the returning VRAM data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_data <= '0;
    end else begin
      case (pix_class_e'(cls_out))
        WINDOW:  vga_data <= vram.vram_data;
        BORDER:  vga_data <= border_color;
        default: vga_data <= PIX_W'(BLACK);
      endcase
    end
  end

endmodule
